// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter sharing one APB master port: IDLE -> SETUP -> ACCESS, 3 cycles minimum per transfer.
// Requesters hold req_valid until their req_ready pulse; ACCESS wait states are bounded by TIMEOUT.
module apb_master_arbiter #(
   parameter int NREQ    = 2,
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 16
) (
   input  logic                     Pclk,
   input  logic                     Presetn,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ*AW-1:0]       req_addr,
   input  logic [NREQ-1:0]          req_write,
   input  logic [NREQ*DW-1:0]       req_wdata,
   output logic [NREQ-1:0]          req_ready,
   output logic [DW-1:0]            rsp_rdata,
   output logic                     rsp_err,
   output logic [$clog2(NREQ)-1:0]  grant_id,
   output logic                     Psel,
   output logic                     Penable,
   output logic [AW-1:0]            Paddr,
   output logic                     Pwrite,
   output logic [DW-1:0]            Pwdata,
   input  logic [DW-1:0]            Prdata,
   input  logic                     Pready,
   input  logic                     Pslverr
);

   localparam int GW = $clog2(NREQ);
   localparam int CW = $clog2(TIMEOUT + 1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETUP  = 2'd1;
   localparam logic [1:0] ST_ACCESS = 2'd2;

   logic [1:0]    state;
   logic [GW-1:0] rr_ptr;
   logic [GW-1:0] win_id;
   logic          win_vld;
   logic [CW-1:0] acc_cnt;
   logic          timed_out;
   logic          done;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_wdata;
   logic          sel_write;

   // Two passes: requesters above the pointer first, then wrap to those at or below it.
   always_comb begin
      win_vld = 1'b0;
      win_id  = rr_ptr;
      for (int i = 0; i < NREQ; i++) begin
         if (!win_vld && req_valid[i] && (GW'(i) > rr_ptr)) begin
            win_vld = 1'b1;
            win_id  = GW'(i);
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (!win_vld && req_valid[i] && (GW'(i) <= rr_ptr)) begin
            win_vld = 1'b1;
            win_id  = GW'(i);
         end
      end
   end

   always_comb begin
      sel_addr  = '0;
      sel_wdata = '0;
      sel_write = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (GW'(i) == win_id) begin
            sel_addr  = req_addr[i*AW +: AW];
            sel_wdata = req_wdata[i*DW +: DW];
            sel_write = req_write[i];
         end
      end
   end

   // Psel/Penable decode straight from state so reset removes them without a clock edge.
   assign Psel      = (state != ST_IDLE);
   assign Penable   = (state == ST_ACCESS);
   assign timed_out = (acc_cnt == CW'(TIMEOUT));
   assign done      = Penable && (Pready || timed_out);
   assign rsp_rdata = Pready ? Prdata : '0;
   assign rsp_err   = Pready ? Pslverr : 1'b1;

   always_comb begin
      req_ready = '0;
      if (done) begin
         req_ready[grant_id] = 1'b1;
      end
   end

   always_ff @(posedge Pclk or negedge Presetn) begin
      if (!Presetn) begin
         state    <= ST_IDLE;
         rr_ptr   <= GW'(NREQ - 1);
         grant_id <= '0;
         Paddr    <= '0;
         Pwrite   <= 1'b0;
         Pwdata   <= '0;
         acc_cnt  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (win_vld) begin
                  state    <= ST_SETUP;
                  rr_ptr   <= win_id;
                  grant_id <= win_id;
                  Paddr    <= sel_addr;
                  Pwrite   <= sel_write;
                  Pwdata   <= sel_wdata;
               end
            end
            ST_SETUP: begin
               state   <= ST_ACCESS;
               acc_cnt <= CW'(1);
            end
            ST_ACCESS: begin
               if (done) begin
                  state   <= ST_IDLE;
                  acc_cnt <= '0;
               end else begin
                  acc_cnt <= acc_cnt + CW'(1);
               end
            end
            default: begin
               state   <= ST_IDLE;
               acc_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Scoreboard bench for apb_master_arbiter: expected completions queued at issue, checked on req_ready.
module tb_apb_master_arbiter;

   localparam int NREQ    = 2;
   localparam int AW      = 32;
   localparam int DW      = 32;
   localparam int TIMEOUT = 16;

   logic                    Pclk;
   logic                    Presetn;
   logic [NREQ-1:0]         req_valid;
   logic [NREQ*AW-1:0]      req_addr;
   logic [NREQ-1:0]         req_write;
   logic [NREQ*DW-1:0]      req_wdata;
   logic [NREQ-1:0]         req_ready;
   logic [DW-1:0]           rsp_rdata;
   logic                    rsp_err;
   logic [$clog2(NREQ)-1:0] grant_id;
   logic                    Psel;
   logic                    Penable;
   logic [AW-1:0]           Paddr;
   logic                    Pwrite;
   logic [DW-1:0]           Pwdata;
   logic [DW-1:0]           Prdata;
   logic                    Pready;
   logic                    Pslverr;

   apb_master_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
      .Pclk(Pclk), .Presetn(Presetn),
      .req_valid(req_valid), .req_addr(req_addr), .req_write(req_write), .req_wdata(req_wdata),
      .req_ready(req_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .grant_id(grant_id),
      .Psel(Psel), .Penable(Penable), .Paddr(Paddr), .Pwrite(Pwrite), .Pwdata(Pwdata),
      .Prdata(Prdata), .Pready(Pready), .Pslverr(Pslverr)
   );

   typedef struct {
      int            id;
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] rdata;
      logic          err;
      logic          chk_rd;
      int            acc;
      int            gap;
   } exp_t;

   exp_t sb[$];

   int checks    = 0;
   int errors    = 0;
   int cyc       = 0;
   int done_cnt  = 0;
   int last_done = 0;
   int sacc      = 0;

   int            s_waits = 0;
   logic          s_stuck = 1'b0;
   logic          s_err   = 1'b0;
   logic [DW-1:0] s_rdata = '0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   initial begin
      Pclk = 1'b0;
      forever #5 Pclk = ~Pclk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=expired exp=finished");
      $fatal(1, "watchdog expired");
   end

   // Slave model: Pready after s_waits wait states unless stuck.
   initial begin
      Pready  = 1'b0;
      Prdata  = '0;
      Pslverr = 1'b0;
      forever begin
         @(posedge Pclk);
         cyc++;
         #1;
         if (Psel && Penable) sacc++;
         else sacc = 0;
         Pready  = !s_stuck && Penable && (sacc > s_waits);
         Prdata  = s_rdata;
         Pslverr = s_err;
      end
   end

   // Completion monitor: pop the scoreboard on every req_ready pulse.
   initial begin
      exp_t e;
      forever begin
         @(negedge Pclk);
         if (Presetn && (|req_ready)) begin
            if (sb.size() == 0) begin
               chk("spurious_rdy", req_ready, '0);
            end else begin
               e = sb.pop_front();
               chk("rdy_vec", req_ready, 64'(1) << e.id);
               chk("grant_id", grant_id, e.id);
               chk("rsp_err", rsp_err, e.err);
               if (e.chk_rd) chk("rsp_rdata", rsp_rdata, e.rdata);
               chk("paddr", Paddr, e.addr);
               chk("pwrite", Pwrite, e.wr);
               if (e.wr) chk("pwdata", Pwdata, e.wdata);
               chk("acc_cycles", sacc, e.acc);
               if (e.gap > 0) chk("gap", cyc - last_done, e.gap);
            end
            last_done = cyc;
            done_cnt++;
         end
      end
   end

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge Pclk); #1;
      while (Psel && n < 100) begin
         @(negedge Pclk); #1;
         n++;
      end
   endtask

   task automatic issue(input int id, input logic wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input int waits, input logic stuck,
                        input logic err, input logic [DW-1:0] rdata);
      exp_t e;
      int   d0, c0, n;
      wait_idle();
      s_waits = waits;
      s_stuck = stuck;
      s_err   = err;
      s_rdata = rdata;
      e.id     = id;
      e.wr     = wr;
      e.addr   = addr;
      e.wdata  = wdata;
      e.err    = stuck ? 1'b1 : err;
      e.rdata  = stuck ? '0 : rdata;
      e.chk_rd = !wr || stuck;
      e.acc    = stuck ? TIMEOUT : waits + 1;
      e.gap    = 0;
      sb.push_back(e);
      req_addr[id*AW +: AW]  = addr;
      req_wdata[id*DW +: DW] = wdata;
      req_write[id]          = wr;
      req_valid[id]          = 1'b1;
      c0 = cyc;
      d0 = done_cnt;
      @(negedge Pclk); #1;
      chk("setup_psel", Psel, 1);
      chk("setup_pen", Penable, 0);
      // Fields changed after grant must not reach the bus.
      req_addr[id*AW +: AW]  = ~addr;
      req_wdata[id*DW +: DW] = ~wdata;
      req_write[id]          = ~wr;
      n = 0;
      while (done_cnt == d0 && n < 100) begin
         @(negedge Pclk); #1;
         n++;
      end
      if (done_cnt == d0) begin
         chk("rdy_never", 0, 1);
         sb.delete();
      end else begin
         chk("latency", cyc - c0, 1 + e.acc);
      end
      req_valid[id] = 1'b0;
      @(negedge Pclk); #1;
      chk("idle_psel", Psel, 0);
   endtask

   task automatic run_both(input int n, input int first);
      exp_t e;
      int   d0, k, id;
      wait_idle();
      s_waits = 0;
      s_stuck = 1'b0;
      s_err   = 1'b0;
      for (int i = 0; i < n; i++) begin
         id       = (first + i) % NREQ;
         e.id     = id;
         e.wr     = 1'b1;
         e.addr   = (id == 0) ? 32'h100 : 32'h200;
         e.wdata  = (id == 0) ? 32'h0000_1111 : 32'h2222_0000;
         e.rdata  = '0;
         e.err    = 1'b0;
         e.chk_rd = 1'b0;
         e.acc    = 1;
         e.gap    = (i == 0) ? 0 : 3;
         sb.push_back(e);
      end
      req_addr  = {32'h200, 32'h100};
      req_wdata = {32'h2222_0000, 32'h0000_1111};
      req_write = 2'b11;
      req_valid = 2'b11;
      d0 = done_cnt;
      k  = 0;
      while (done_cnt < d0 + n && k < 3 * n + 20) begin
         @(negedge Pclk); #1;
         k++;
      end
      if (done_cnt < d0 + n) begin
         chk("both_done", done_cnt - d0, n);
         sb.delete();
      end
      req_valid = 2'b00;
   endtask

   initial begin
      int d0, n;
      Presetn   = 1'b0;
      req_valid = '0;
      req_addr  = '0;
      req_write = '0;
      req_wdata = '0;
      repeat (3) @(negedge Pclk);
      #1;
      chk("rst_psel", Psel, 0);
      chk("rst_pen", Penable, 0);
      chk("rst_pwrite", Pwrite, 0);
      chk("rst_paddr", Paddr, 0);
      chk("rst_pwdata", Pwdata, 0);
      chk("rst_gid", grant_id, 0);
      chk("rst_rdy", req_ready, 0);
      Presetn = 1'b1;

      issue(0, 1'b1, 32'h10, 32'hA5A5_A5A5, 0, 1'b0, 1'b0, 32'h0);
      issue(1, 1'b0, 32'h44, 32'h0, 3, 1'b0, 1'b0, 32'hDEAD_BEEF);
      run_both(4, 0);
      issue(0, 1'b0, 32'h80, 32'h0, 0, 1'b1, 1'b0, 32'h1234_5678);
      issue(1, 1'b0, 32'h84, 32'h0, 1, 1'b0, 1'b0, 32'hCAFE_F00D);
      issue(0, 1'b1, 32'h20, 32'h1122_3344, 0, 1'b0, 1'b1, 32'h0);
      issue(1, 1'b1, 32'h24, 32'h5566_7788, 0, 1'b0, 1'b0, 32'h0);

      // Reset in the middle of a stalled req1 access.
      wait_idle();
      s_stuck = 1'b1;
      req_addr[AW +: AW] = 32'h300;
      req_write[1]       = 1'b1;
      req_valid          = 2'b10;
      d0 = done_cnt;
      n  = 0;
      while (!Penable && n < 20) begin
         @(negedge Pclk); #1;
         n++;
      end
      chk("pre_rst_pen", Penable, 1);
      Presetn = 1'b0;
      #1;
      chk("arst_psel", Psel, 0);
      chk("arst_pen", Penable, 0);
      chk("arst_rdy", req_ready, 0);
      chk("arst_gid", grant_id, 0);
      req_valid = 2'b00;
      s_stuck   = 1'b0;
      @(negedge Pclk); #1;
      Presetn = 1'b1;
      chk("arst_no_done", done_cnt, d0);
      run_both(2, 0);

      wait_idle();
      chk("sb_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
